// File: rtl/game_flow_pkg.sv
// ----------------------------------------------------------------------------
// game_flow_pkg
//   Shared definitions for the game flow sequencer: screen/state encodings,
//   the all-ones colour constant and the per-channel dimming helper used for
//   the pause screen.
// ----------------------------------------------------------------------------
package game_flow_pkg;

   // Screen encodings are visible on the screen output, so values are fixed.
   typedef enum logic [1:0] {
      ST_START = 2'd0,
      ST_PLAY  = 2'd1,
      ST_OVER  = 2'd2,
      ST_PAUSE = 2'd3
   } state_t;

   // Widest colour the helpers handle; callers zero-extend and truncate.
   localparam int MAX_COLOR_W = 48;

   localparam logic [MAX_COLOR_W-1:0] WHITE = '1;

   // Halve every RGB channel: shift the whole word right by one, then clear
   // each channel MSB so no bit leaks in from the neighbouring channel.
   function automatic logic [MAX_COLOR_W-1:0] dim_colour(
      input logic [MAX_COLOR_W-1:0] c,
      input int                     chan_w
   );
      logic [MAX_COLOR_W-1:0] r;
      r = c >> 1;
      for (int i = 0; i < MAX_COLOR_W; i++) begin
         if ((i % chan_w) == (chan_w - 1)) r[i] = 1'b0;
      end
      return r;
   endfunction

endpackage

// File: rtl/game_flow_ctrl_if.sv
// ----------------------------------------------------------------------------
// game_flow_ctrl_if
//   Bundles the sequencer's button, pixel and status signals.
//   master : stimulus side (buttons, game_over, x/y, per-screen colours out;
//            screen, level, play_en, game_restart, colour_out in)
//   slave  : game_flow_ctrl side (mirror of master)
// ----------------------------------------------------------------------------
interface game_flow_ctrl_if
   import game_flow_pkg::*;
#(
   parameter int LVL_W   = 2,
   parameter int COLOR_W = 12,
   parameter int XY_W    = 10
);
   logic               sel_btn;
   logic               next_btn;
   logic               pause_btn;
   logic               game_over;
   logic [XY_W-1:0]    x;
   logic [XY_W-1:0]    y;
   logic [COLOR_W-1:0] colour_start;
   logic [COLOR_W-1:0] colour_play;
   logic [COLOR_W-1:0] colour_over;
   state_t             screen;
   logic [LVL_W-1:0]   level;
   logic               play_en;
   logic               game_restart;
   logic [COLOR_W-1:0] colour_out;

   modport master (
      output sel_btn, next_btn, pause_btn, game_over, x, y,
             colour_start, colour_play, colour_over,
      input  screen, level, play_en, game_restart, colour_out
   );

   modport slave (
      input  sel_btn, next_btn, pause_btn, game_over, x, y,
             colour_start, colour_play, colour_over,
      output screen, level, play_en, game_restart, colour_out
   );
endinterface

// File: rtl/game_flow_ctrl_btn_edge.sv
// ----------------------------------------------------------------------------
// btn_edge
//   Rising-edge detector for one debounced button level.
//   clk, reset : clock, asynchronous active-high reset
//   i_btn      : debounced button level
//   o_rise     : high for the cycle where i_btn is 1 and was 0 last cycle
//   History resets to 1 so a button held through reset gives no edge.
// ----------------------------------------------------------------------------
module btn_edge (
   input  logic clk,
   input  logic reset,
   input  logic i_btn,
   output logic o_rise
);
   logic r_prev;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_prev <= 1'b1;
      else       r_prev <= i_btn;
   end

   assign o_rise = i_btn & ~r_prev;
endmodule

// File: rtl/game_flow_ctrl.sv
// ----------------------------------------------------------------------------
// game_flow_ctrl
//   Top-level game sequencer: START (level menu) / PLAY / PAUSE / OVER.
//   clk, reset : clock, asynchronous active-high reset
//   bus        : game_flow_ctrl_if.slave
//                in : sel_btn, next_btn, pause_btn, game_over, x, y,
//                     colour_start, colour_play, colour_over
//                out: screen, level, play_en, game_restart, colour_out
//   Button edges are ignored for a guard window after each state change;
//   OVER returns to START on select or after OVER_TIMEOUT cycles (0 = never).
// ----------------------------------------------------------------------------
module game_flow_ctrl
   import game_flow_pkg::*;
#(
   parameter int NUM_LEVELS   = 3,
   parameter int LVL_W        = 2,
   parameter int COLOR_W      = 12,
   parameter int XY_W         = 10,
   parameter int BOX_X0       = 250,
   parameter int BOX_Y0       = 200,
   parameter int BOX_SIZE     = 8,
   parameter int BOX_PITCH    = 32,
   parameter int GUARD_CYC    = 1000,
   parameter int OVER_TIMEOUT = 500000000
) (
   input  logic           clk,
   input  logic           reset,
   game_flow_ctrl_if.slave bus
);
   localparam int GUARD_W = (GUARD_CYC > 1)    ? $clog2(GUARD_CYC)    : 1;
   localparam int OVER_W  = (OVER_TIMEOUT > 1) ? $clog2(OVER_TIMEOUT) : 1;
   localparam int HIT_N   = 2 ** LVL_W;

   state_t             r_state, w_next;
   logic [LVL_W-1:0]   r_level;
   logic [GUARD_W-1:0] r_guard;
   logic [OVER_W-1:0]  r_over_cnt;
   logic               r_restart, r_play_en;
   logic               w_sel_raw, w_nbtn_raw, w_pause_raw;
   logic               w_sel_rise, w_nbtn_rise, w_pause_rise;
   logic               w_guard_on, w_timeout;
   logic [HIT_N-1:0]   w_hit;
   logic [31:0]        w_x32, w_y32;
   logic [COLOR_W-1:0] w_dim, w_colour;

   btn_edge u_sel_edge   (.clk(clk), .reset(reset), .i_btn(bus.sel_btn),   .o_rise(w_sel_raw));
   btn_edge u_next_edge  (.clk(clk), .reset(reset), .i_btn(bus.next_btn),  .o_rise(w_nbtn_raw));
   btn_edge u_pause_edge (.clk(clk), .reset(reset), .i_btn(bus.pause_btn), .o_rise(w_pause_raw));

   // Edge history keeps tracking during the guard; only the edges are masked.
   assign w_guard_on   = (r_guard != '0);
   assign w_sel_rise   = w_sel_raw   & ~w_guard_on;
   assign w_nbtn_rise  = w_nbtn_raw  & ~w_guard_on;
   assign w_pause_rise = w_pause_raw & ~w_guard_on;
   assign w_timeout    = (OVER_TIMEOUT != 0) && (r_over_cnt == OVER_W'(OVER_TIMEOUT - 1));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= ST_START;
      else       r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_START: if (w_sel_rise) w_next = ST_PLAY;
         ST_PLAY: begin
            if (bus.game_over)      w_next = ST_OVER;
            else if (w_pause_rise)  w_next = ST_PAUSE;
         end
         ST_PAUSE: begin
            if (w_pause_rise)       w_next = ST_PLAY;
            else if (w_sel_rise)    w_next = ST_START;
         end
         ST_OVER: if (w_sel_rise || w_timeout) w_next = ST_START;
         default: w_next = ST_START;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_level    <= '0;
         r_guard    <= '0;
         r_over_cnt <= '0;
         r_restart  <= 1'b0;
         r_play_en  <= 1'b0;
      end else begin
         r_restart <= (r_state == ST_START) && (w_next == ST_PLAY);
         r_play_en <= (w_next == ST_PLAY);
         // Select wins over next in the same cycle, so level holds then.
         if ((r_state == ST_START) && !w_sel_rise && w_nbtn_rise)
            r_level <= (r_level == LVL_W'(NUM_LEVELS - 1)) ? '0 : r_level + LVL_W'(1);
         if (w_next != r_state)
            r_guard <= (GUARD_CYC == 0) ? '0 : GUARD_W'(GUARD_CYC - 1);
         else if (w_guard_on)
            r_guard <= r_guard - GUARD_W'(1);
         if ((r_state == ST_OVER) && (w_next == ST_OVER))
            r_over_cnt <= r_over_cnt + OVER_W'(1);
         else
            r_over_cnt <= '0;
      end
   end

   // 32-bit compares: boxes lying past the coordinate range never match.
   assign w_x32 = 32'(bus.x);
   assign w_y32 = 32'(bus.y);

   generate
      for (genvar gi = 0; gi < HIT_N; gi++) begin : g_box
         if (gi < NUM_LEVELS) begin : g_real
            localparam int Y0 = BOX_Y0 + gi * BOX_PITCH;
            assign w_hit[gi] = (w_x32 >= 32'(BOX_X0)) && (w_x32 <= 32'(BOX_X0 + BOX_SIZE - 1)) &&
                               (w_y32 >= 32'(Y0))     && (w_y32 <= 32'(Y0 + BOX_SIZE - 1));
         end else begin : g_pad
            assign w_hit[gi] = 1'b0;
         end
      end
   endgenerate

   assign w_dim = COLOR_W'(dim_colour(MAX_COLOR_W'(bus.colour_play), COLOR_W / 3));

   always_comb begin
      w_colour = bus.colour_start;
      case (r_state)
         ST_START: if (|w_hit) w_colour = w_hit[r_level] ? COLOR_W'(WHITE) : '0;
         ST_PLAY:  w_colour = bus.colour_play;
         ST_OVER:  w_colour = bus.colour_over;
         ST_PAUSE: w_colour = w_dim;
         default:  w_colour = bus.colour_start;
      endcase
   end

   assign bus.screen       = r_state;
   assign bus.level        = r_level;
   assign bus.play_en      = r_play_en;
   assign bus.game_restart = r_restart;
   assign bus.colour_out   = w_colour;
endmodule

// File: tb/tb_game_flow_ctrl.sv
// ----------------------------------------------------------------------------
// tb_game_flow_ctrl
//   Directed and randomized bench for game_flow_ctrl with a reference model
//   that tracks screen, level, guard window and OVER dwell time in cycles.
// ----------------------------------------------------------------------------
module tb_game_flow_ctrl;
   import game_flow_pkg::*;

   localparam int NUM_LEVELS   = 3;
   localparam int LVL_W        = 2;
   localparam int COLOR_W      = 12;
   localparam int XY_W         = 10;
   localparam int BOX_X0       = 250;
   localparam int BOX_Y0       = 200;
   localparam int BOX_SIZE     = 8;
   localparam int BOX_PITCH    = 32;
   localparam int GUARD_CYC    = 10;
   localparam int OVER_TIMEOUT = 50;

   localparam int S_START = 0, S_PLAY = 1, S_OVER = 2, S_PAUSE = 3;

   logic clk   = 1'b0;
   logic reset = 1'b1;

   game_flow_ctrl_if #(.LVL_W(LVL_W), .COLOR_W(COLOR_W), .XY_W(XY_W)) bus ();

   game_flow_ctrl #(
      .NUM_LEVELS(NUM_LEVELS), .LVL_W(LVL_W), .COLOR_W(COLOR_W), .XY_W(XY_W),
      .BOX_X0(BOX_X0), .BOX_Y0(BOX_Y0), .BOX_SIZE(BOX_SIZE), .BOX_PITCH(BOX_PITCH),
      .GUARD_CYC(GUARD_CYC), .OVER_TIMEOUT(OVER_TIMEOUT)
   ) dut (
      .clk(clk),
      .reset(reset),
      .bus(bus)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Reference model state
   int cyc = 0;
   int m_scr, m_lvl, m_chg, m_over_in;
   bit m_pulse, mp_s, mp_n, mp_p;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   task automatic model_reset();
      m_scr     = S_START;
      m_lvl     = 0;
      m_chg     = -1000000;
      m_over_in = 0;
      m_pulse   = 1'b0;
      mp_s = 1'b1; mp_n = 1'b1; mp_p = 1'b1;
   endtask

   // One clock edge of the rules: edges count only GUARD_CYC or more cycles
   // after the last screen change; OVER ends OVER_TIMEOUT cycles after entry.
   task automatic model_edge(input bit s, input bit n, input bit p, input bit g);
      bit ok, rs, rn, rp;
      int nxt;
      cyc++;
      ok = (GUARD_CYC == 0) || ((cyc - m_chg) >= GUARD_CYC);
      rs = ok && s && !mp_s;
      rn = ok && n && !mp_n;
      rp = ok && p && !mp_p;
      mp_s = s; mp_n = n; mp_p = p;
      nxt = m_scr;
      case (m_scr)
         S_START: begin
            if (rs)      nxt = S_PLAY;
            else if (rn) m_lvl = (m_lvl + 1) % NUM_LEVELS;
         end
         S_PLAY:  if (g) nxt = S_OVER; else if (rp) nxt = S_PAUSE;
         S_PAUSE: if (rp) nxt = S_PLAY; else if (rs) nxt = S_START;
         default: if (rs || (OVER_TIMEOUT != 0 && (cyc - m_over_in) == OVER_TIMEOUT)) nxt = S_START;
      endcase
      m_pulse = (m_scr == S_START) && (nxt == S_PLAY);
      if (nxt != m_scr) begin
         m_chg = cyc;
         if (nxt == S_OVER) m_over_in = cyc;
      end
      m_scr = nxt;
   endtask

   function automatic logic [11:0] dim12(input logic [11:0] c);
      int v, acc;
      acc = 0;
      for (int ch = 0; ch < 3; ch++) begin
         v   = (int'(c) >> (4 * ch)) % 16;
         acc = acc + (v / 2) * (1 << (4 * ch));
      end
      return 12'(acc);
   endfunction

   function automatic logic [11:0] exp_colour();
      int xi, yi, top;
      bit found;
      logic [11:0] r;
      xi = int'(bus.x);
      yi = int'(bus.y);
      r  = bus.colour_start;
      found = 1'b0;
      case (m_scr)
         S_PLAY:  r = bus.colour_play;
         S_OVER:  r = bus.colour_over;
         S_PAUSE: r = dim12(bus.colour_play);
         default: begin
            for (int i = 0; i < NUM_LEVELS; i++) begin
               top = BOX_Y0 + i * BOX_PITCH;
               if (!found && xi >= BOX_X0 && xi < BOX_X0 + BOX_SIZE && yi >= top && yi < top + BOX_SIZE) begin
                  found = 1'b1;
                  r = (i == m_lvl) ? 12'hFFF : 12'h000;
               end
            end
         end
      endcase
      return r;
   endfunction

   task automatic check_all(input string ph);
      chk({ph, ".screen"},  32'(bus.screen),       32'(m_scr));
      chk({ph, ".level"},   32'(bus.level),        32'(m_lvl));
      chk({ph, ".play_en"}, 32'(bus.play_en),      32'(m_scr == S_PLAY));
      chk({ph, ".restart"}, 32'(bus.game_restart), 32'(m_pulse));
      chk({ph, ".colour"},  32'(bus.colour_out),   32'(exp_colour()));
   endtask

   // Inputs change 1 time unit after a rising edge; outputs are checked at
   // the same point after the next edge.
   task automatic step(input bit s, input bit n, input bit p, input bit g);
      bus.sel_btn   = s;
      bus.next_btn  = n;
      bus.pause_btn = p;
      bus.game_over = g;
      @(posedge clk);
      model_edge(s, n, p, g);
      #1;
      check_all("step");
   endtask

   initial begin
      bus.sel_btn = 0; bus.next_btn = 0; bus.pause_btn = 0; bus.game_over = 0;
      bus.x = '0; bus.y = '0;
      bus.colour_start = '0; bus.colour_play = '0; bus.colour_over = '0;
      model_reset();

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      check_all("reset");
      reset = 1'b0;

      // Level cycling in the menu and indicator box colours
      bus.x = XY_W'(BOX_X0); bus.y = XY_W'(BOX_Y0); bus.colour_start = 12'h123;
      step(0, 0, 0, 0); chk("box0_lvl0", 32'(bus.colour_out), 32'h0FFF);
      step(0, 1, 0, 0); chk("lvl_1", 32'(bus.level), 1); chk("box0_lvl1", 32'(bus.colour_out), 0);
      step(0, 0, 0, 0);
      step(0, 1, 0, 0); chk("lvl_2", 32'(bus.level), 2);
      step(0, 0, 0, 0);
      step(0, 1, 0, 0); chk("lvl_wrap", 32'(bus.level), 0); chk("box0_again", 32'(bus.colour_out), 32'h0FFF);
      bus.x = XY_W'(BOX_X0 + BOX_SIZE);
      step(0, 0, 0, 0); chk("outside_box", 32'(bus.colour_out), 32'h0123);
      bus.x = XY_W'(BOX_X0 + 3); bus.y = XY_W'(BOX_Y0 + 2 * BOX_PITCH + BOX_SIZE - 1);
      step(0, 0, 0, 0); chk("box2_dark", 32'(bus.colour_out), 0);

      // Select and same-cycle next: start game, level unchanged, one pulse
      bus.colour_play = 12'hFFF; bus.colour_over = 12'hABC;
      step(1, 1, 0, 0);
      chk("to_play", 32'(bus.screen), S_PLAY);
      chk("restart_hi", 32'(bus.game_restart), 1);
      chk("play_en", 32'(bus.play_en), 1);
      chk("lvl_keep", 32'(bus.level), 0);
      step(0, 0, 0, 0); chk("restart_lo", 32'(bus.game_restart), 0);

      // Pause and resume after the guard window
      repeat (10) step(0, 0, 0, 0);
      step(0, 0, 1, 0); chk("to_pause", 32'(bus.screen), S_PAUSE); chk("dim", 32'(bus.colour_out), 32'h0777);
      step(0, 0, 0, 0);
      repeat (10) step(0, 0, 0, 0);
      step(0, 0, 1, 0); chk("resume", 32'(bus.screen), S_PLAY);
      step(0, 0, 0, 0);

      // game_over beats pause; timeout back to START
      repeat (10) step(0, 0, 0, 0);
      step(0, 0, 1, 1); chk("to_over", 32'(bus.screen), S_OVER); chk("over_col", 32'(bus.colour_out), 32'h0ABC);
      repeat (48) step(0, 0, 0, 0);
      step(0, 0, 0, 0); chk("over_49", 32'(bus.screen), S_OVER);
      step(0, 0, 0, 0); chk("timeout", 32'(bus.screen), S_START);

      // Guard: held select and a pause press inside the window do nothing
      repeat (10) step(0, 0, 0, 0);
      step(0, 1, 0, 0); chk("lvl_pre", 32'(bus.level), 1);
      step(0, 0, 0, 0);
      step(1, 0, 0, 0); chk("guard_enter", 32'(bus.screen), S_PLAY);
      repeat (3) step(1, 0, 0, 0);
      step(0, 0, 0, 0);
      step(0, 0, 1, 0); chk("guard_pause", 32'(bus.screen), S_PLAY);
      step(0, 0, 0, 0);

      // Asynchronous reset mid-PLAY, select held through release
      #2;
      reset = 1'b1;
      bus.sel_btn = 1'b1;
      #1;
      model_reset();
      chk("arst_screen", 32'(bus.screen), S_START);
      chk("arst_level", 32'(bus.level), 0);
      chk("arst_play_en", 32'(bus.play_en), 0);
      chk("arst_restart", 32'(bus.game_restart), 0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      repeat (3) step(1, 0, 0, 0);
      chk("held_sel", 32'(bus.screen), S_START);
      step(0, 0, 0, 0);
      step(1, 0, 0, 0); chk("fresh_sel", 32'(bus.screen), S_PLAY);

      // Randomized phase against the model
      for (int k = 0; k < 3000; k++) begin
         bit s, n, p, g;
         if ($urandom_range(0, 3) == 0) begin
            bus.x = XY_W'(BOX_X0 - 3 + int'($urandom_range(0, 14)));
            bus.y = XY_W'(BOX_Y0 - 3 + int'($urandom_range(0, 3 * BOX_PITCH + 6)));
            bus.colour_start = 12'($urandom);
            bus.colour_play  = 12'($urandom);
            bus.colour_over  = 12'($urandom);
         end
         s = ($urandom_range(0, 4) == 0);
         n = ($urandom_range(0, 2) == 0);
         p = ($urandom_range(0, 4) == 0);
         g = ($urandom_range(0, 39) == 0);
         step(s, n, p, g);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
